// File: rtl/udp_tx_scheduler.sv
// udp_tx_scheduler: round-robin sharing of one udp_packet transmitter between N_SRC payload sources.
// Latency: grant 2 clks after a request is first seen in IDLE; o_done 1 clk after tx_en is seen low.
// Backpressure: requests are held levels; they wait, unsampled, while a packet or the gap is in progress.
module udp_tx_scheduler #(
  parameter int N_SRC      = 4,
  parameter int GAP_CYCLES = 12,
  parameter int TIMEOUT    = 64,
  parameter int MAX_LEN    = 1472
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_SRC-1:0]      i_req,
  input  logic [16*N_SRC-1:0]   i_len,
  input  logic [16*N_SRC-1:0]   i_port,
  input  logic [8*N_SRC-1:0]    i_stream,
  output logic [N_SRC-1:0]      o_src_rd,
  output logic [N_SRC-1:0]      o_grant,
  output logic [N_SRC-1:0]      o_done,
  output logic [N_SRC-1:0]      o_err,
  output logic                  o_enable,
  output logic [15:0]           o_udp_len,
  output logic [15:0]           o_dst_port,
  output logic [7:0]            o_udp_stream,
  input  logic                  i_udp_rd,
  input  logic                  i_tx_en,
  output logic                  o_busy,
  output logic [15:0]           o_pkt_count
);

  localparam int IW   = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int CMAX = (GAP_CYCLES > TIMEOUT) ? GAP_CYCLES : TIMEOUT;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [IW:0]    NSRC_W    = (IW+1)'(N_SRC);
  localparam logic [15:0]    MAX_LEN_W = 16'(MAX_LEN);
  localparam logic [CW-1:0]  GAP_LAST  = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0]  TO_LAST   = CW'(TIMEOUT - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CHECK  = 3'd1;
  localparam logic [2:0] S_LAUNCH = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_BUSY   = 3'd4;
  localparam logic [2:0] S_GAP    = 3'd5;

  logic [2:0]       r_state;
  logic [IW-1:0]    r_ptr;
  logic [IW-1:0]    r_sel;
  logic [CW-1:0]    r_cnt;
  logic [N_SRC-1:0] r_grant;
  logic [N_SRC-1:0] r_done;
  logic [N_SRC-1:0] r_err;
  logic             r_enable;
  logic [15:0]      r_len;
  logic [15:0]      r_port;
  logic             r_busy;
  logic [15:0]      r_pkt;

  logic             w_pick_vld;
  logic [IW-1:0]    w_pick;
  logic [IW:0]      w_sum;
  logic [N_SRC-1:0] w_sel_oh;
  logic [15:0]      w_len;
  logic [15:0]      w_port;
  logic [7:0]       w_stream;

  // Round-robin pick: scan offsets from farthest to nearest so the nearest requester after r_ptr wins.
  always_comb begin
    w_pick_vld = 1'b0;
    w_pick     = r_ptr;
    w_sum      = '0;
    for (int i = N_SRC; i >= 1; i--) begin
      w_sum = {1'b0, r_ptr} + (IW+1)'(i);
      if (w_sum >= NSRC_W) w_sum = w_sum - NSRC_W;
      if (i_req[w_sum[IW-1:0]]) begin
        w_pick_vld = 1'b1;
        w_pick     = w_sum[IW-1:0];
      end
    end
  end

  assign w_sel_oh = {{(N_SRC-1){1'b0}}, 1'b1} << r_sel;

  // Length and port of the source chosen in IDLE, examined during CHECK.
  always_comb begin
    w_len  = '0;
    w_port = '0;
    for (int k = 0; k < N_SRC; k++) begin
      if (r_sel == IW'(k)) begin
        w_len  = i_len[16*k +: 16];
        w_port = i_port[16*k +: 16];
      end
    end
  end

  // Payload byte of the granted source; zero when nothing is granted.
  always_comb begin
    w_stream = '0;
    for (int k = 0; k < N_SRC; k++) begin
      if (r_grant[k]) w_stream = w_stream | i_stream[8*k +: 8];
    end
  end

  // Scheduler FSM and all registered outputs; done/err are single-cycle pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_ptr    <= IW'(N_SRC - 1);
      r_sel    <= '0;
      r_cnt    <= '0;
      r_grant  <= '0;
      r_done   <= '0;
      r_err    <= '0;
      r_enable <= 1'b0;
      r_len    <= '0;
      r_port   <= '0;
      r_busy   <= 1'b0;
      r_pkt    <= '0;
    end else begin
      r_done <= '0;
      r_err  <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_pick_vld) begin
            r_sel   <= w_pick;
            r_ptr   <= w_pick;
            r_busy  <= 1'b1;
            r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (w_len > MAX_LEN_W) begin
            r_err   <= w_sel_oh;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_len    <= w_len;
            r_port   <= w_port;
            r_grant  <= w_sel_oh;
            r_enable <= 1'b1;
            r_cnt    <= '0;
            r_state  <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          // enable spans exactly the two LAUNCH cycles
          if (r_cnt == '0) begin
            r_cnt <= CW'(1);
          end else begin
            r_enable <= 1'b0;
            r_cnt    <= '0;
            r_state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (i_tx_en) begin
            r_state <= S_BUSY;
          end else if (r_cnt == TO_LAST) begin
            r_err   <= r_grant;
            r_grant <= '0;
            r_cnt   <= '0;
            r_state <= S_GAP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_BUSY: begin
          if (!i_tx_en) begin
            r_done  <= r_grant;
            r_grant <= '0;
            r_pkt   <= r_pkt + 16'd1;
            r_cnt   <= '0;
            r_state <= S_GAP;
          end
        end
        S_GAP: begin
          if (r_cnt == GAP_LAST) begin
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_grant  <= '0;
          r_enable <= 1'b0;
          r_busy   <= 1'b0;
          r_cnt    <= '0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

  assign o_src_rd     = r_grant & {N_SRC{i_udp_rd}};
  assign o_udp_stream = w_stream;
  assign o_grant      = r_grant;
  assign o_done       = r_done;
  assign o_err        = r_err;
  assign o_enable     = r_enable;
  assign o_udp_len    = r_len;
  assign o_dst_port   = r_port;
  assign o_busy       = r_busy;
  assign o_pkt_count  = r_pkt;

endmodule
